// File: rtl/alu_issue.sv
// alu_issue: RV32I ALU-class decode followed by a two-entry skid buffer.
// The decode is combinational on the input. The main entry (M) drives the out_* ports.
// The skid entry (S) absorbs one instruction under backpressure, so in_ready comes straight from a flop.
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_AND  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_ILL  = 4'b1111
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP    = 7'b0110011,
    OPC_OPIMM = 7'b0010011,
    OPC_LUI   = 7'b0110111,
    OPC_AUIPC = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         op;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_field;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  // The rs1 index is consumed upstream by the register file; only its data arrives here.
  assign unused_rs1_field = ^in_instr[19:15];

  logic            legal;
  alu_op_e         op_sel;
  logic [XLEN-1:0] a_sel;
  logic [XLEN-1:0] b_sel;
  entry_t          dec;

  // Decode the incoming instruction into ALU operands and an operation code.
  always_comb begin
    legal  = 1'b0;
    op_sel = OP_ILL;
    a_sel  = '0;
    b_sel  = '0;
    unique case (opcode)
      OPC_OP: begin
        a_sel = in_rs1_data;
        b_sel = in_rs2_data;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          unique case (funct3)
            3'b000: op_sel = OP_ADD;
            3'b001: op_sel = OP_SLL;
            3'b010: op_sel = OP_SLT;
            3'b011: op_sel = OP_SLTU;
            3'b100: op_sel = OP_XOR;
            3'b101: op_sel = OP_SRL;
            3'b110: op_sel = OP_OR;
            default: op_sel = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            legal  = 1'b1;
            op_sel = OP_SUB;
          end else if (funct3 == 3'b101) begin
            legal  = 1'b1;
            op_sel = OP_SRA;
          end
        end
      end
      OPC_OPIMM: begin
        a_sel = in_rs1_data;
        b_sel = imm_i;
        legal = 1'b1;
        unique case (funct3)
          3'b000: op_sel = OP_ADD;
          3'b010: op_sel = OP_SLT;
          3'b011: op_sel = OP_SLTU;
          3'b100: op_sel = OP_XOR;
          3'b110: op_sel = OP_OR;
          3'b111: op_sel = OP_AND;
          3'b001: begin
            b_sel  = shamt;
            op_sel = OP_SLL;
            legal  = (funct7 == 7'b0000000);
          end
          default: begin
            b_sel = shamt;
            if (funct7 == 7'b0000000) begin
              op_sel = OP_SRL;
            end else if (funct7 == 7'b0100000) begin
              op_sel = OP_SRA;
            end else begin
              legal = 1'b0;
            end
          end
        endcase
      end
      OPC_LUI: begin
        legal  = 1'b1;
        op_sel = OP_ADD;
        a_sel  = '0;
        b_sel  = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        op_sel = OP_ADD;
        a_sel  = in_pc;
        b_sel  = imm_u;
      end
      default: legal = 1'b0;
    endcase

    dec.rd = in_instr[11:7];
    if (legal) begin
      dec.a       = a_sel;
      dec.b       = b_sel;
      dec.op      = op_sel;
      dec.illegal = 1'b0;
    end else begin
      dec.a       = '0;
      dec.b       = '0;
      dec.op      = OP_ILL;
      dec.illegal = 1'b1;
    end
  end

  entry_t m_q;
  entry_t s_q;
  logic   m_valid;
  logic   s_valid;
  logic   m_free;
  logic   capture;

  // M frees up this cycle when it is empty or when its entry is consumed.
  assign m_free  = ~m_valid | out_ready;
  // Flush is handled by giving it priority in the register update.
  assign capture = in_valid & ~s_valid;

  // Update the main/skid storage. The order of precedence is flush, then draining S into M, then capture.
  // While S holds an entry, in_ready is low, so an S->M move never coincides with a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q     <= '0;
      s_q     <= '0;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_free) begin
      if (s_valid) begin
        m_q     <= s_q;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (capture) begin
        m_q     <= dec;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (capture) begin
      s_q     <= dec;
      s_valid <= 1'b1;
    end
  end

  assign in_ready    = ~s_valid;
  assign out_valid   = m_valid;
  assign out_a       = m_q.a;
  assign out_b       = m_q.b;
  assign out_alu_op  = m_q.op;
  assign out_rd      = m_q.rd;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue. It decodes a set of hand-encoded vectors, then exercises backpressure, flush, asynchronous reset and a random-handshake ordering stress.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] v_instr [10];
  logic [31:0] v_pc    [10];
  logic [31:0] v_rs1   [10];
  logic [31:0] v_rs2   [10];
  logic [31:0] e_a     [10];
  logic [31:0] e_b     [10];
  logic [3:0]  e_op    [10];
  logic [4:0]  e_rd    [10];
  logic        e_ill   [10];

  alu_issue #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_op  (out_alu_op),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx);
    chk(tag, {out_a, out_b, out_alu_op, out_rd, out_illegal},
        {e_a[idx], e_b[idx], e_op[idx], e_rd[idx], e_ill[idx]});
  endtask

  task automatic drive(input int idx, input logic v);
    in_valid    = v;
    in_instr    = v_instr[idx];
    in_pc       = v_pc[idx];
    in_rs1_data = v_rs1[idx];
    in_rs2_data = v_rs2[idx];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int e;
    int sent;
    int got;
    int cyc;
    int q[$];

    // Each vector: instr, pc, rs1, rs2 -> a, b, op, rd, illegal.
    // add x3,x1,x2
    v_instr[0]=32'h002081B3; v_pc[0]=32'h0;   v_rs1[0]=32'd10;        v_rs2[0]=32'd20;
    e_a[0]=32'd10;           e_b[0]=32'd20;         e_op[0]=4'h0; e_rd[0]=5'd3;  e_ill[0]=1'b0;
    // srai x5,x6,4
    v_instr[1]=32'h40435293; v_pc[1]=32'h4;   v_rs1[1]=32'h80000000;  v_rs2[1]=32'h1234;
    e_a[1]=32'h80000000;     e_b[1]=32'd4;          e_op[1]=4'h7; e_rd[1]=5'd5;  e_ill[1]=1'b0;
    // sltiu x7,x8,-1
    v_instr[2]=32'hFFF43393; v_pc[2]=32'h8;   v_rs1[2]=32'd5;         v_rs2[2]=32'd9;
    e_a[2]=32'd5;            e_b[2]=32'hFFFFFFFF;   e_op[2]=4'h8; e_rd[2]=5'd7;  e_ill[2]=1'b0;
    // auipc x9,0x12345 at pc 0x100
    v_instr[3]=32'h12345497; v_pc[3]=32'h100; v_rs1[3]=32'h77;        v_rs2[3]=32'h88;
    e_a[3]=32'h100;          e_b[3]=32'h12345000;   e_op[3]=4'h0; e_rd[3]=5'd9;  e_ill[3]=1'b0;
    // xor with funct7=0100000 is illegal
    v_instr[4]=32'h4020C233; v_pc[4]=32'h10;  v_rs1[4]=32'd10;        v_rs2[4]=32'd20;
    e_a[4]=32'h0;            e_b[4]=32'h0;          e_op[4]=4'hF; e_rd[4]=5'd4;  e_ill[4]=1'b1;
    // lw x10,0(x1): load opcode is illegal here
    v_instr[5]=32'h0000A503; v_pc[5]=32'h14;  v_rs1[5]=32'h55;        v_rs2[5]=32'h66;
    e_a[5]=32'h0;            e_b[5]=32'h0;          e_op[5]=4'hF; e_rd[5]=5'd10; e_ill[5]=1'b1;
    // lui x11,0xABCDE
    v_instr[6]=32'hABCDE5B7; v_pc[6]=32'h18;  v_rs1[6]=32'h55;        v_rs2[6]=32'h66;
    e_a[6]=32'h0;            e_b[6]=32'hABCDE000;   e_op[6]=4'h0; e_rd[6]=5'd11; e_ill[6]=1'b0;
    // sub x12,x1,x2
    v_instr[7]=32'h40208633; v_pc[7]=32'h1C;  v_rs1[7]=32'd10;        v_rs2[7]=32'd20;
    e_a[7]=32'd10;           e_b[7]=32'd20;         e_op[7]=4'h1; e_rd[7]=5'd12; e_ill[7]=1'b0;
    // slli x13,x1,31
    v_instr[8]=32'h01F09693; v_pc[8]=32'h20;  v_rs1[8]=32'h3;         v_rs2[8]=32'hABC;
    e_a[8]=32'h3;            e_b[8]=32'h1F;         e_op[8]=4'h5; e_rd[8]=5'd13; e_ill[8]=1'b0;
    // xori x14,x1,-2
    v_instr[9]=32'hFFE0C713; v_pc[9]=32'h24;  v_rs1[9]=32'h7;         v_rs2[9]=32'h0;
    e_a[9]=32'h7;            e_b[9]=32'hFFFFFFFE;   e_op[9]=4'h2; e_rd[9]=5'd14; e_ill[9]=1'b0;

    // Reset state
    tick;
    tick;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", {out_a, out_b, out_alu_op, out_rd, out_illegal}, '0);
    rst_n = 1'b1;
    tick;

    // First instruction: one-cycle latency
    drive(0, 1'b1);
    tick;
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1'b1);
    chk_out("add", 0);

    // Decode table, streamed at one per cycle
    out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      drive(i, 1'b1);
      tick;
      chk($sformatf("dec%0d_valid", i), out_valid, 1'b1);
      chk_out($sformatf("dec%0d", i), i);
    end
    in_valid = 1'b0;
    tick;
    chk("dec_drained", out_valid, 1'b0);

    // Backpressure: M then S fill, in_ready drops, then everything drains in order
    out_ready = 1'b0;
    drive(0, 1'b1);
    tick;
    chk("bp_m_ready", in_ready, 1'b1);
    chk("bp_m_valid", out_valid, 1'b1);
    drive(1, 1'b1);
    tick;
    chk("bp_s_ready", in_ready, 1'b0);
    chk_out("bp_hold0", 0);
    drive(2, 1'b1);
    tick;
    chk("bp_blocked_ready", in_ready, 1'b0);
    chk_out("bp_stable0", 0);
    out_ready = 1'b1;
    tick;
    chk_out("bp_out1", 1);
    chk("bp_ready_back", in_ready, 1'b1);
    tick;
    chk_out("bp_out2", 2);
    drive(3, 1'b1);
    tick;
    chk_out("bp_out3", 3);
    in_valid = 1'b0;
    tick;
    chk("bp_empty", out_valid, 1'b0);

    // Flush with M full, concurrent capture and concurrent fire
    out_ready = 1'b0;
    drive(4, 1'b1);
    tick;
    out_ready = 1'b1;
    drive(7, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flushA_valid", out_valid, 1'b0);
    chk("flushA_ready", in_ready, 1'b1);
    tick;
    chk("flushA_no_ghost", out_valid, 1'b0);

    // Flush with M and S both full and input valid
    out_ready = 1'b0;
    drive(5, 1'b1);
    tick;
    drive(6, 1'b1);
    tick;
    chk("flushB_full", in_ready, 1'b0);
    drive(8, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flushB_valid", out_valid, 1'b0);
    chk("flushB_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick;
    chk("flushB_no_ghost", out_valid, 1'b0);
    drive(9, 1'b1);
    tick;
    in_valid = 1'b0;
    chk_out("post_flush", 9);
    tick;
    chk("post_flush_empty", out_valid, 1'b0);

    // Asynchronous reset while holding entries
    out_ready = 1'b0;
    drive(0, 1'b1);
    tick;
    drive(1, 1'b1);
    tick;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_data", {out_a, out_b, out_alu_op, out_rd, out_illegal}, '0);
    tick;
    rst_n = 1'b1;
    tick;

    // Random handshake stress: output order must equal accepted order
    sent = 0;
    got = 0;
    cyc = 0;
    while ((sent < 1000 || q.size() > 0 || out_valid) && cyc < 20000) begin
      idx = $urandom_range(0, 9);
      drive(idx, (sent < 1000) && ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("stress_extra_output", 1'b1, 1'b0);
        end else begin
          e = q.pop_front();
          chk_out("stress", e);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(idx);
        sent++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stress_count", got, 1000);
    chk("stress_in_time", (cyc < 20000), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
